// File: rtl/vote_seq_ctrl.sv
// Serial ballot controller: collects up to NUM_VOTERS one-hot ballots over a
// valid/ready handshake, closes on full count or idle timeout, presents a plurality winner.
module vote_seq_ctrl #(
   parameter int NUM_VOTERS = 5,
   parameter int TIMEOUT    = 16,
   localparam int CNT_W     = $clog2(NUM_VOTERS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             vote_valid,
   input  logic [2:0]       vote_in,
   output logic             vote_ready,
   output logic             busy,
   output logic [2:0]       result,
   output logic             result_valid,
   input  logic             result_ack,
   output logic [CNT_W-1:0] invalid_cnt
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COLLECT = 2'd1;
   localparam logic [1:0] ST_TALLY   = 2'd2;
   localparam logic [1:0] ST_RESULT  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
   logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
   logic [CNT_W-1:0] cnt_c_q, cnt_c_d;
   logic [CNT_W-1:0] total_q, total_d;
   logic [CNT_W-1:0] invalid_q, invalid_d;
   logic [7:0]       idle_q, idle_d;
   logic [2:0]       result_q, result_d;
   logic [2:0]       winner_s;

   // Plurality winner with fixed tie priority A > B > C; no valid ballot yields 000
   always_comb begin
      winner_s = 3'b000;
      if ((cnt_a_q | cnt_b_q | cnt_c_q) == {CNT_W{1'b0}}) begin
         winner_s = 3'b000;
      end else if ((cnt_a_q >= cnt_b_q) && (cnt_a_q >= cnt_c_q)) begin
         winner_s = 3'b100;
      end else if (cnt_b_q >= cnt_c_q) begin
         winner_s = 3'b010;
      end else begin
         winner_s = 3'b001;
      end
   end

   // Next-state and counter update logic
   always_comb begin
      state_d   = state_q;
      cnt_a_d   = cnt_a_q;
      cnt_b_d   = cnt_b_q;
      cnt_c_d   = cnt_c_q;
      total_d   = total_q;
      invalid_d = invalid_q;
      idle_d    = idle_q;
      result_d  = result_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_COLLECT;
               cnt_a_d   = {CNT_W{1'b0}};
               cnt_b_d   = {CNT_W{1'b0}};
               cnt_c_d   = {CNT_W{1'b0}};
               total_d   = {CNT_W{1'b0}};
               invalid_d = {CNT_W{1'b0}};
               idle_d    = 8'd0;
               result_d  = 3'b000;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_COLLECT: begin
            if (vote_valid) begin
               total_d = total_q + CNT_W'(1);
               idle_d  = 8'd0;
               case (vote_in)
                  3'b100:  cnt_a_d   = cnt_a_q + CNT_W'(1);
                  3'b010:  cnt_b_d   = cnt_b_q + CNT_W'(1);
                  3'b001:  cnt_c_d   = cnt_c_q + CNT_W'(1);
                  default: invalid_d = invalid_q + CNT_W'(1);
               endcase
            end else begin
               idle_d = idle_q + 8'd1;
            end
            // Either close condition (or both at once) moves to TALLY a single time
            if ((total_d == CNT_W'(NUM_VOTERS)) || (idle_d == 8'(TIMEOUT))) begin
               state_d = ST_TALLY;
            end else begin
               state_d = ST_COLLECT;
            end
         end
         ST_TALLY: begin
            result_d = winner_s;
            state_d  = ST_RESULT;
         end
         ST_RESULT: begin
            if (result_ack) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESULT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_a_q   <= {CNT_W{1'b0}};
         cnt_b_q   <= {CNT_W{1'b0}};
         cnt_c_q   <= {CNT_W{1'b0}};
         total_q   <= {CNT_W{1'b0}};
         invalid_q <= {CNT_W{1'b0}};
         idle_q    <= 8'd0;
         result_q  <= 3'b000;
      end else begin
         state_q   <= state_d;
         cnt_a_q   <= cnt_a_d;
         cnt_b_q   <= cnt_b_d;
         cnt_c_q   <= cnt_c_d;
         total_q   <= total_d;
         invalid_q <= invalid_d;
         idle_q    <= idle_d;
         result_q  <= result_d;
      end
   end

   assign vote_ready   = (state_q == ST_COLLECT);
   assign busy         = (state_q == ST_COLLECT) || (state_q == ST_TALLY);
   assign result_valid = (state_q == ST_RESULT);
   assign result       = result_q;
   assign invalid_cnt  = invalid_q;

endmodule

// File: tb/tb_vote_seq_ctrl.sv
// Randomized bench for vote_seq_ctrl: a round-level model tracks ballots, the close
// condition and the expected winner, and every output is compared against it on negedges.
module tb_vote_seq_ctrl;

   localparam int NV    = 5;
   localparam int TMO   = 16;
   localparam int CW    = $clog2(NV + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          vote_valid = 1'b0;
   logic [2:0]    vote_in = 3'b000;
   logic          vote_ready;
   logic          busy;
   logic [2:0]    result;
   logic          result_valid;
   logic          result_ack = 1'b0;
   logic [CW-1:0] invalid_cnt;

   int checks = 0;
   int errors = 0;
   logic [3:0] ballot_q[$];

   vote_seq_ctrl #(.NUM_VOTERS(NV), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .vote_valid(vote_valid),
      .vote_in(vote_in), .vote_ready(vote_ready), .busy(busy), .result(result),
      .result_valid(result_valid), .result_ack(result_ack), .invalid_cnt(invalid_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [2:0] ref_winner(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      if (a + b + c == 0) return 3'b000;
      if (a == m) return 3'b100;
      if (b == m) return 3'b010;
      return 3'b001;
   endfunction

   task automatic push_valid(input logic [2:0] v);
      ballot_q.push_back({1'b1, v});
   endtask

   // Plays one round from IDLE: drains ballot_q while collecting, then holds and acks the result.
   task automatic run_round(input int hold, input bit coinc_start);
      int cnt[3];
      int total, inv, idle, cyc;
      bit open;
      logic [3:0] e;
      logic [2:0] exp_res;
      cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
      total = 0; inv = 0; idle = 0; cyc = 0; open = 1'b1;
      @(negedge clk);
      check_eq("idle_busy", {31'd0, busy}, 32'd0);
      check_eq("idle_ready", {31'd0, vote_ready}, 32'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("start_clr_inv", {{(32-CW){1'b0}}, invalid_cnt}, 32'd0);
      check_eq("start_clr_res", {29'd0, result}, 32'd0);
      while (open && cyc < 400) begin
         check_eq("col_ready", {31'd0, vote_ready}, 32'd1);
         check_eq("col_busy", {31'd0, busy}, 32'd1);
         check_eq("col_rvalid", {31'd0, result_valid}, 32'd0);
         check_eq("col_inv", {{(32-CW){1'b0}}, invalid_cnt}, inv);
         e = (ballot_q.size() > 0) ? ballot_q.pop_front() : 4'b0000;
         vote_valid = e[3];
         vote_in    = e[2:0];
         start      = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         if (e[3]) begin
            total++;
            idle = 0;
            if (e[2:0] == 3'b100) cnt[0]++;
            else if (e[2:0] == 3'b010) cnt[1]++;
            else if (e[2:0] == 3'b001) cnt[2]++;
            else inv++;
         end else begin
            idle++;
         end
         if (total == NV || idle == TMO) open = 1'b0;
         cyc++;
      end
      check_eq("close_budget", {31'd0, open}, 32'd0);
      exp_res = ref_winner(cnt[0], cnt[1], cnt[2]);
      // TALLY cycle: bus keeps offering ballots, none may be taken
      vote_valid = 1'b1;
      vote_in    = 3'($urandom_range(0, 7));
      start      = 1'b1;
      check_eq("tally_ready", {31'd0, vote_ready}, 32'd0);
      check_eq("tally_busy", {31'd0, busy}, 32'd1);
      check_eq("tally_rvalid", {31'd0, result_valid}, 32'd0);
      @(negedge clk);
      check_eq("res_rvalid", {31'd0, result_valid}, 32'd1);
      check_eq("res_value", {29'd0, result}, {29'd0, exp_res});
      check_eq("res_inv", {{(32-CW){1'b0}}, invalid_cnt}, inv);
      check_eq("res_busy", {31'd0, busy}, 32'd0);
      check_eq("res_ready", {31'd0, vote_ready}, 32'd0);
      for (int h = 0; h < hold; h++) begin
         vote_in = 3'($urandom_range(0, 7));
         start   = $urandom_range(0, 1);
         @(negedge clk);
         check_eq("hold_rvalid", {31'd0, result_valid}, 32'd1);
         check_eq("hold_value", {29'd0, result}, {29'd0, exp_res});
         check_eq("hold_inv", {{(32-CW){1'b0}}, invalid_cnt}, inv);
      end
      result_ack = 1'b1;
      start      = coinc_start;
      vote_valid = 1'b0;
      @(negedge clk);
      result_ack = 1'b0;
      start      = 1'b0;
      check_eq("ack_rvalid", {31'd0, result_valid}, 32'd0);
      check_eq("ack_busy", {31'd0, busy}, 32'd0);
      check_eq("ack_res_held", {29'd0, result}, {29'd0, exp_res});
      check_eq("ack_inv_held", {{(32-CW){1'b0}}, invalid_cnt}, inv);
      if (coinc_start) begin
         @(negedge clk);
         check_eq("no_restart", {31'd0, busy}, 32'd0);
      end
      ballot_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_ready"}, {31'd0, vote_ready}, 32'd0);
      check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check_eq({tag, "_res"}, {29'd0, result}, 32'd0);
      check_eq({tag, "_rvalid"}, {31'd0, result_valid}, 32'd0);
      check_eq({tag, "_inv"}, {{(32-CW){1'b0}}, invalid_cnt}, 32'd0);
   endtask

   initial begin
      #2;
      check_reset_outputs("rst");
      @(negedge clk);
      rst_n = 1'b1;

      push_valid(3'b100); push_valid(3'b100); push_valid(3'b010);
      push_valid(3'b010); push_valid(3'b001);
      run_round(2, 1'b0);

      push_valid(3'b100); push_valid(3'b100); push_valid(3'b010);
      push_valid(3'b001); push_valid(3'b001);
      run_round(1, 1'b0);

      push_valid(3'b010); push_valid(3'b100); push_valid(3'b010);
      push_valid(3'b001); push_valid(3'b001);
      run_round(0, 1'b1);

      push_valid(3'b001); push_valid(3'b011); push_valid(3'b000);
      push_valid(3'b001); push_valid(3'b010);
      run_round(10, 1'b0);

      push_valid(3'b010); push_valid(3'b010);
      run_round(1, 1'b0);

      run_round(1, 1'b0);

      // Abort mid-collect after three ballots
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vote_valid = 1'b1;
         vote_in    = 3'b100;
         @(negedge clk);
      end
      vote_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NV; i++) push_valid(3'b001);
      run_round(1, 1'b0);

      // Random rounds: mixed codes, gaps, occasional timeout-length idle runs
      for (int r = 0; r < 40; r++) begin
         int n;
         n = $urandom_range(0, 8);
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 9) == 0) begin
               for (int g = 0; g < $urandom_range(1, 20); g++) ballot_q.push_back(4'b0000);
            end else if ($urandom_range(0, 3) == 0) begin
               ballot_q.push_back(4'b0000);
            end else if ($urandom_range(0, 4) == 0) begin
               ballot_q.push_back({1'b1, 3'($urandom_range(0, 7))});
            end else begin
               ballot_q.push_back({1'b1, 3'(3'b001 << $urandom_range(0, 2))});
            end
         end
         run_round($urandom_range(0, 4), $urandom_range(0, 1));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
